// File: rtl/sram_bridge.sv
// AVR-side bridge to an asynchronous SRAM: serial address load,
// single or auto-increment accesses with fixed setup/hold framing.
module sram_bridge #(
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              avr_si,
  input  logic              avr_sreg_en,
  input  logic [2:0]        avr_ctrl,
  input  logic              avr_req,
  input  logic              avr_oe,
  inout  wire  [DATA_W-1:0] avr_data,
  output logic              avr_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_cnt;
  logic                r_wr;
  logic                r_inc;
  logic                w_accept;
  logic                w_last;
  logic                w_sram_drv;

  assign w_accept = (r_state == S_IDLE) && avr_req &&
                    (avr_ctrl >= 3'd1) && (avr_ctrl <= 3'd4);
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_last) w_next = S_HOLD;
      S_HOLD:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    avr_ack    = 1'b0;
    sram_ce_n  = 1'b0;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    w_sram_drv = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        sram_ce_n = 1'b1;
      end
      S_SETUP: ;
      S_ACCESS: begin
        sram_oe_n  = r_wr;
        sram_we_n  = ~r_wr;
        w_sram_drv = r_wr;
      end
      S_HOLD: begin
        avr_ack    = 1'b1;
        w_sram_drv = r_wr;
      end
      default: ;
    endcase
  end

  // A command beats a shift in the same IDLE cycle.
  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      r_addr  <= '0;
      r_rdata <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_inc   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr    <= (avr_ctrl == 3'd2) || (avr_ctrl == 3'd4);
            r_inc   <= (avr_ctrl >= 3'd3);
            r_wdata <= avr_data;
            r_cnt   <= '0;
          end else if (avr_sreg_en) begin
            r_addr <= {r_addr[ADDR_W-2:0], avr_si};
          end
        end
        S_SETUP: r_cnt <= '0;
        S_ACCESS: begin
          if (!w_last) r_cnt <= r_cnt + 4'd1;
          if (w_last && !r_wr) r_rdata <= sram_data;
        end
        S_HOLD: if (r_inc) r_addr <= r_addr + 1'b1;
        default: ;
      endcase
    end
  end

  assign sram_addr = r_addr;
  assign sram_data = w_sram_drv ? r_wdata : 'z;
  assign avr_data  = !avr_oe ? r_rdata : 'z;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed + randomized bench for sram_bridge with a behavioural
// address/memory reference and an SRAM device model.
module tb_sram_bridge;

  localparam int AW = 21;
  localparam int DW = 8;
  localparam int W  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          si = 1'b0;
  logic          sreg = 1'b0;
  logic          req = 1'b0;
  logic          oe = 1'b1;
  logic [2:0]    ctrl = 3'd0;
  wire  [DW-1:0] avr_data;
  wire  [DW-1:0] sram_data;
  logic          ack, busy, ce_n, oe_n, we_n;
  logic [AW-1:0] saddr;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_wd = '0;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [int];
  logic [AW-1:0] ref_addr;
  int            ncmp = 0;
  int            nfail = 0;

  sram_bridge #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) dut (
    .avr_clk(clk), .avr_reset(rst), .avr_si(si),
    .avr_sreg_en(sreg), .avr_ctrl(ctrl), .avr_req(req),
    .avr_oe(oe), .avr_data(avr_data), .avr_ack(ack),
    .busy(busy), .sram_addr(saddr), .sram_data(sram_data),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
  );

  always #5 clk = ~clk;

  assign avr_data  = tb_drv ? tb_wd : 'z;
  assign sram_data = (!ce_n && !oe_n) ? sram_mem[saddr] : 'z;

  always @(posedge clk)
    if (!ce_n && !we_n) sram_mem[saddr] <= sram_data;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [AW-1:0] a);
    for (int i = AW - 1; i >= 0; i--) begin
      si   = a[i];
      sreg = 1'b1;
      tick;
    end
    sreg     = 1'b0;
    si       = 1'b0;
    ref_addr = a;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [DW-1:0] d,
                        input logic sr, output int ack_at,
                        output int wlo, output int olo,
                        output int bad, output logic [AW-1:0] a_ack,
                        output logic [DW-1:0] rd);
    ack_at = -1;
    wlo    = 0;
    olo    = 0;
    bad    = 0;
    a_ack  = '0;
    rd     = '0;
    ctrl   = c;
    tb_wd  = d;
    tb_drv = (c == 3'd2) || (c == 3'd4);
    oe     = 1'b1;
    req    = 1'b1;
    sreg   = sr;
    si     = 1'b1;
    tick;
    req    = 1'b0;
    tb_drv = 1'b0;
    ctrl   = 3'($urandom);
    for (int t = 1; t <= W + 10; t++) begin
      if (ce_n !== 1'b0) bad++;
      if ((t == 1) && (oe_n !== 1'b1 || we_n !== 1'b1)) bad++;
      if (we_n === 1'b0) wlo++;
      if (oe_n === 1'b0) olo++;
      if (ack === 1'b1) begin
        if (oe_n !== 1'b1 || we_n !== 1'b1) bad++;
        ack_at = t;
        a_ack  = saddr;
        oe     = 1'b0;
        #1;
        rd     = avr_data;
        oe     = 1'b1;
        break;
      end
      tick;
    end
    tick;
    sreg = 1'b0;
    si   = 1'b0;
    ctrl = 3'd0;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] c,
                         input logic [DW-1:0] d, input logic sr);
    int            ack_at, wlo, olo, bad;
    logic [AW-1:0] a_ack;
    logic [DW-1:0] rd;
    bit            is_rd, is_wr;
    is_rd = (c == 3'd1) || (c == 3'd3);
    is_wr = (c == 3'd2) || (c == 3'd4);
    do_cmd(c, d, sr, ack_at, wlo, olo, bad, a_ack, rd);
    chk({tag, ".ack_at"}, ack_at, W + 2);
    chk({tag, ".we_low"}, wlo, is_wr ? W : 0);
    chk({tag, ".oe_low"}, olo, is_rd ? W : 0);
    chk({tag, ".strobes"}, bad, 0);
    chk({tag, ".addr"}, a_ack, ref_addr);
    if (is_rd) chk({tag, ".rdata"}, rd, ref_mem[int'(ref_addr)]);
    if (is_wr) ref_mem[int'(ref_addr)] = d;
    if (c >= 3'd3) ref_addr = ref_addr + 1'b1;
    chk({tag, ".addr_after"}, saddr, ref_addr);
    chk({tag, ".busy_after"}, busy, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            n, prev;

    ref_addr = '0;
    tick;
    chk("rst.busy", busy, 0);
    chk("rst.ack", ack, 0);
    chk("rst.strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rst.addr", saddr, 0);
    tick;
    rst = 1'b0;
    tick;

    shift_in(21'h0ABCDE);
    chk("shift.addr", saddr, 21'h0ABCDE);
    run_cmd("wr5a", 3'd2, 8'h5A, 1'b0);
    chk("wr5a.mem", sram_mem[21'h0ABCDE], 8'h5A);
    run_cmd("rd5a", 3'd1, 8'h00, 1'b0);

    shift_in(21'h1FFFFF);
    run_cmd("wrinc_wrap", 3'd4, 8'($urandom), 1'b0);
    chk("wrap.addr", saddr, 21'h000000);

    shift_in(21'h000010);
    for (int i = 0; i < 4; i++)
      run_cmd("fill", 3'd4, 8'($urandom), i == 2);

    shift_in(21'h000010);
    ctrl = 3'd3;
    oe   = 1'b0;
    req  = 1'b1;
    n    = 0;
    prev = -1;
    for (int t = 1; t <= 40; t++) begin
      tick;
      if (ack === 1'b1) begin
        chk("burst.addr", saddr, ref_addr);
        chk("burst.data", avr_data, ref_mem[int'(ref_addr)]);
        if (prev >= 0) chk("burst.period", t - prev, W + 3);
        prev     = t;
        ref_addr = ref_addr + 1'b1;
        n++;
        if (n == 4) begin
          req = 1'b0;
          break;
        end
      end
    end
    chk("burst.count", n, 4);
    tick;
    oe = 1'b1;
    chk("burst.final", saddr, 21'h000014);

    a = AW'($urandom);
    shift_in(a);
    ctrl   = 3'd2;
    tb_wd  = 8'hC3;
    tb_drv = 1'b1;
    req    = 1'b1;
    tick;
    req    = 1'b0;
    tb_drv = 1'b0;
    tick;
    chk("abort.we_active", we_n, 0);
    rst = 1'b1;
    #1;
    chk("abort.strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("abort.ack", ack, 0);
    chk("abort.busy", busy, 0);
    chk("abort.addr", saddr, 0);
    tick;
    chk("abort.ack_held", ack, 0);
    tick;
    rst      = 1'b0;
    ref_addr = '0;
    tick;
    run_cmd("post_rst_wr", 3'd2, 8'($urandom), 1'b0);
    run_cmd("post_rst_rd", 3'd1, 8'h00, 1'b0);

    shift_in(AW'($urandom));
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: ctrl = 3'd0;
        1: ctrl = 3'd5;
        2: ctrl = 3'd6;
        default: ctrl = 3'd7;
      endcase
      req = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick;
        chk("noop.outs", {ce_n, oe_n, we_n, ack, busy}, 5'b11100);
      end
      req = 1'b0;
      chk("noop.addr", saddr, ref_addr);
    end
    ctrl = 3'd0;
    run_cmd("busy_shift", 3'd2, 8'($urandom), 1'b1);

    for (int k = 0; k < 10; k++) begin
      a = AW'($urandom);
      d = DW'($urandom);
      shift_in(a);
      run_cmd("rnd_wr", $urandom_range(0, 1) ? 3'd4 : 3'd2, d,
              1'($urandom));
      shift_in(a);
      run_cmd("rnd_rd", $urandom_range(0, 1) ? 3'd3 : 3'd1, 8'h00,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 21, meaning SRAM address width (2..24).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data width of both buses (8 or 16).
REQ-003 The block SHALL have parameter WAIT_CYC, default 1, meaning SRAM strobe-active cycles per access (1..15).
REQ-004 The block SHALL have port avr_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 The block SHALL have port avr_reset  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port avr_si  in  1  serial address bit, MSB first.
REQ-007 The block SHALL have port avr_sreg_en  in  1  shift enable for the address register.
REQ-008 The block SHALL have port avr_ctrl  in  3  command: 1 read, 2 write, 3 read+inc, 4 write+inc, others no-op.
REQ-009 The block SHALL have port avr_req  in  1  command strobe, level-sampled.
REQ-010 The block SHALL have port avr_oe  in  1  active-low; bridge drives avr_data when 0.
REQ-011 The block SHALL have port avr_data  inout  DATA_W  AVR data bus.
REQ-012 The block SHALL have port avr_ack  out  1  access-complete pulse.
REQ-013 The block SHALL have port busy  out  1  high when state is not IDLE.
REQ-014 The block SHALL have port sram_addr  out  ADDR_W  SRAM address, equal to the address register.
REQ-015 The block SHALL have port sram_data  inout  DATA_W  SRAM data bus.
REQ-016 The block SHALL have ports sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-017 In IDLE, with avr_sreg_en=1 and no accepted command, the address register SHALL shift: addr <= {addr[ADDR_W-2:0], avr_si}.
REQ-018 Shifting SHALL be ignored while busy=1.
REQ-019 A command SHALL be accepted in IDLE when avr_req=1 and avr_ctrl is 1..4; other codes SHALL be ignored with no ack and no strobes.
REQ-020 If avr_req and avr_sreg_en are both high in IDLE, the command SHALL win and no shift SHALL occur that cycle.
REQ-021 Write data SHALL be captured from avr_data on the accept edge.
REQ-022 The FSM SHALL have states IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYC cycles, internal counter) -> HOLD (1 cycle) -> IDLE.
REQ-023 In SETUP, sram_ce_n SHALL be 0 and sram_oe_n/sram_we_n SHALL be 1.
REQ-024 In ACCESS, sram_ce_n SHALL be 0, with sram_oe_n=0 for reads or sram_we_n=0 for writes.
REQ-025 In HOLD, sram_ce_n SHALL be 0 and sram_oe_n/sram_we_n SHALL be 1.
REQ-026 For reads, sram_data SHALL be latched into the read register on the edge leaving the last ACCESS cycle.
REQ-027 sram_data SHALL be driven with the write register only in ACCESS and HOLD of a write command; otherwise it SHALL be Z.
REQ-028 avr_data SHALL be driven with the read register whenever avr_oe=0, otherwise Z; the AVR keeps avr_oe=1 during write accept.
REQ-029 avr_ack SHALL be 1 exactly in the HOLD cycle, i.e. WAIT_CYC+2 cycles after the accept edge.
REQ-030 For commands 3 and 4, the address SHALL increment by 1 on the HOLD->IDLE edge, wrapping from all-ones to 0.
REQ-031 If avr_req is held high, the next command SHALL be accepted on the first IDLE cycle, giving a burst period of WAIT_CYC+3 cycles.
REQ-032 Changes to avr_ctrl after accept SHALL have no effect on the access in progress.

Reset
REQ-033 avr_reset=1 SHALL asynchronously force state IDLE, address/read/write registers and wait counter to 0, avr_ack=0, busy=0, strobes to 1, and sram_data to Z.
REQ-034 Reset asserted mid-access SHALL abort the access with no ack and no address increment; the first command after release SHALL start from SETUP.

Verification
REQ-035 The bench SHALL shift 21 bits 0x0ABCDE, then issue write of 0x5A -> sram_addr=0x0ABCDE, we_n low for 1 cycle, ack at accept+3, and SRAM model holds 0x5A.
REQ-036 The bench SHALL issue read at 0x0ABCDE with avr_oe=0 after ack -> avr_data=0x5A, oe_n low exactly WAIT_CYC cycles.
REQ-037 The bench SHALL set addr=0x1FFFFF and issue write+inc -> after HOLD, sram_addr=0x000000.
REQ-038 The bench SHALL hold avr_req=1 with read+inc for 4 accesses from 0x10 -> reads at 0x10..0x13, acks spaced 4 cycles, final addr 0x14.
REQ-039 The bench SHALL assert reset during ACCESS of a write -> strobes high and sram_data Z immediately, no ack, addr=0.
REQ-040 The bench SHALL issue avr_ctrl=7 with avr_req=1, and shift while busy -> no strobes, no ack, address unchanged.
